midi_event_parser: RTL

- Sits between the SPI slave's Avalon-ST source (one MOSI byte per `rx_valid` pulse) and the DDS voice/phase-accumulator logic.
- Parses the raw MIDI byte stream with running status, filters by channel and emits Note On/Off events through a small first-word-fall-through (FWFT) event FIFO.
- Also maintains a monophonic gate / active-note status for the oscillator and envelope.
- Replaces ad-hoc byte counting clocked off the valid strobe; everything runs on the system clock.

---
 rtl/midi_event_parser.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/midi_event_parser.sv
// MIDI byte-stream parser: running status, channel filter, Note On/Off FWFT event FIFO, mono gate.
// Define MIDI_OMNI_EN to accept Note On/Off on all 16 channels.
module midi_event_parser #(
    parameter int MIDI_CHANNEL = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_note_on,
    output logic [6:0] evt_note,
    output logic [6:0] evt_velocity,
    output logic       gate,
    output logic [6:0] active_note,
    output logic       overflow_err,
    input  logic       clear_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SKIP
    } state_t;

    state_t      state;
    logic        rs_valid;
    logic        rs_on;
    logic [6:0]  note_q;

    logic [14:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        take;
    logic        is_rt;
    logic        is_sys;
    logic        is_note;
    logic        chan_ok;
    logic        complete;
    logic        new_on;
    logic        full;
    logic        pop;
    logic        push;
    logic [14:0] new_evt;

    always_comb begin
        take     = rx_valid & rx_ready;
        is_rt    = (rx_data[7:3] == 5'b11111);
        is_sys   = (rx_data[7:3] == 5'b11110);
        is_note  = (rx_data[7:5] == 3'b100);
`ifdef MIDI_OMNI_EN
        chan_ok  = 1'b1;
`else
        chan_ok  = (rx_data[3:0] == 4'(MIDI_CHANNEL));
`endif
        complete = take & ~rx_data[7] & (state == WAIT_D2);
        // Note On with zero velocity is a Note Off
        new_on   = rs_on & (rx_data[6:0] != 7'd0);
        new_evt  = {new_on, note_q, rx_data[6:0]};
        full     = (count == FULL);
        evt_valid = (count != '0);
        pop      = evt_ready & evt_valid;
        push     = complete & (~full | pop);
    end

    assign evt_note_on  = mem[rd_ptr][14];
    assign evt_note     = mem[rd_ptr][13:7];
    assign evt_velocity = mem[rd_ptr][6:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            rs_valid    <= 1'b0;
            rs_on       <= 1'b0;
            note_q      <= '0;
            rx_ready    <= 1'b0;
            gate        <= 1'b0;
            active_note <= '0;
        end else begin
            rx_ready <= 1'b1;
            if (take) begin
                if (is_rt) begin
                    state <= state;
                end else if (is_sys) begin
                    rs_valid <= 1'b0;
                    state    <= IDLE;
                end else if (rx_data[7]) begin
                    if (is_note && chan_ok) begin
                        rs_valid <= 1'b1;
                        rs_on    <= rx_data[4];
                        state    <= WAIT_D1;
                    end else begin
                        rs_valid <= 1'b0;
                        state    <= SKIP;
                    end
                end else begin
                    unique case (state)
                        IDLE: begin
                            if (rs_valid) begin
                                note_q <= rx_data[6:0];
                                state  <= WAIT_D2;
                            end
                        end
                        WAIT_D1: begin
                            note_q <= rx_data[6:0];
                            state  <= WAIT_D2;
                        end
                        WAIT_D2: begin
                            state <= IDLE;
                            if (new_on) begin
                                active_note <= note_q;
                                gate        <= 1'b1;
                            end else if (note_q == active_note) begin
                                gate <= 1'b0;
                            end
                        end
                        SKIP: begin
                            state <= SKIP;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_evt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (clear_err) begin
                overflow_err <= 1'b0;
            end else if (complete && full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
